// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Optional feature macro used by this block: RF_WRITE_BYPASS_EN.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One buffered MDU result; live drops to 0 when a younger pipe write kills it.
    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] wa;
        logic [XLEN-1:0]       wd;
    } wb_entry_t;

    // Which source the arbiter picked this cycle (exposed for debug).
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_PIPE = 2'd1,
        SEL_MDU  = 2'd2,
        SEL_DROP = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between the writeback sources, the regfile and the arbiter.
// Optional feature macro: RF_WRITE_BYPASS_EN adds the same-cycle bypass ports.
//
// Handshake: the MDU result transfers on a cycle where mdu_valid && mdu_ready
// are both high at the rising edge; the source keeps mdu_* stable while
// mdu_valid is high and mdu_ready is low. The pipeline side has no ready and
// is always accepted.
interface rf_write_arbiter_if;
    import rf_pkg::*;

    logic                  pipe_valid;
    logic [REG_ADDR_W-1:0] pipe_wa;
    logic [XLEN-1:0]       pipe_wd;
    logic                  mdu_valid;
    logic                  mdu_ready;
    logic [REG_ADDR_W-1:0] mdu_wa;
    logic [XLEN-1:0]       mdu_wd;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_wa;
    logic [XLEN-1:0]       rf_wd;
    logic [REG_ADDR_W-1:0] q_addr;
    logic                  q_pending;
    logic                  stall_req;
    wb_sel_e               dbg_sel;
`ifdef RF_WRITE_BYPASS_EN
    logic [REG_ADDR_W-1:0] byp_ra1;
    logic [REG_ADDR_W-1:0] byp_ra2;
    logic [XLEN-1:0]       byp_rd1;
    logic [XLEN-1:0]       byp_rd2;
    logic                  byp_hit1;
    logic                  byp_hit2;
`endif

    // Sources / regfile / decode side.
    modport master (
        output pipe_valid, pipe_wa, pipe_wd,
        output mdu_valid, mdu_wa, mdu_wd,
        output q_addr,
`ifdef RF_WRITE_BYPASS_EN
        output byp_ra1, byp_ra2,
        input  byp_rd1, byp_rd2, byp_hit1, byp_hit2,
`endif
        input  mdu_ready, rf_we, rf_wa, rf_wd, q_pending, stall_req, dbg_sel
    );

    // Arbiter side.
    modport slave (
        input  pipe_valid, pipe_wa, pipe_wd,
        input  mdu_valid, mdu_wa, mdu_wd,
        input  q_addr,
`ifdef RF_WRITE_BYPASS_EN
        input  byp_ra1, byp_ra2,
        output byp_rd1, byp_rd2, byp_hit1, byp_hit2,
`endif
        output mdu_ready, rf_we, rf_wa, rf_wd, q_pending, stall_req, dbg_sel
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// Tagged MDU result buffer: push/pop pointers with a wrap bit, kill-by-address
// of buffered entries, and a pending-write query for hazard detection.
// Slots outside the occupied range always carry live=0, so the query and the
// kill can scan every slot without an occupancy mask.
// Optional feature macro of this block: RF_WRITE_BYPASS_EN (not used here).
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [REG_ADDR_W-1:0] push_wa_i,
    input  logic [XLEN-1:0]       push_wd_i,
    input  logic                  pop_i,
    input  logic                  kill_i,
    input  logic [REG_ADDR_W-1:0] kill_wa_i,
    input  logic [REG_ADDR_W-1:0] q_addr_i,
    output wb_entry_t             head_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  q_pending_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_idx, rd_idx;

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head_o  = mem_q[rd_idx];

    // Next entry contents: kill matching entries, retire the head, store the push.
    always_comb begin
        mem_d = mem_q;
        if (kill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].wa == kill_wa_i) begin
                    mem_d[i].live = 1'b0;
                end
            end
        end
        if (pop_i) begin
            mem_d[rd_idx].live = 1'b0;
        end
        // A same-cycle pipe write to the same register is younger, so the push lands dead.
        if (push_i) begin
            mem_d[wr_idx].live = !(kill_i && (push_wa_i == kill_wa_i));
            mem_d[wr_idx].wa   = push_wa_i;
            mem_d[wr_idx].wd   = push_wd_i;
        end
    end

    // Pointer advance on push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    end

    // Hazard query: any live buffered entry aimed at q_addr (x0 never pends).
    always_comb begin
        q_pending_o = 1'b0;
        if (q_addr_i != REG_ZERO) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].live && (mem_q[i].wa == q_addr_i)) begin
                    q_pending_o = 1'b1;
                end
            end
        end
    end

    // Storage and pointer registers; reset discards every buffered entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter. The pipeline writeback always wins; MDU
// results wait in a tagged buffer and drain on pipe-idle cycles. A pipe write
// kills older buffered results to the same register. If the buffer is blocked
// for STARVE_MAX cycles, stall_req asks the pipeline to hold writeback.
// Optional feature macro: RF_WRITE_BYPASS_EN adds a combinational read bypass
// off the registered write port for the async-read regfile.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    wb_sel_e               sel;
    wb_entry_t             head;
    logic                  fifo_empty, fifo_full;
    logic                  push, pop, kill;
    logic                  fifo_q_pending;

    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_wa_q, rf_wa_d;
    logic [XLEN-1:0]       rf_wd_q, rf_wd_d;
    logic [CW-1:0]         starve_q, starve_d;
    logic                  stall_req_q, stall_req_d;

    // x0 pushes are acknowledged but never stored.
    assign push = bus.mdu_valid && !fifo_full && (bus.mdu_wa != REG_ZERO);
    assign kill = bus.pipe_valid && (bus.pipe_wa != REG_ZERO);
    assign pop  = (sel == SEL_MDU) || (sel == SEL_DROP);

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_wa_i   (bus.mdu_wa),
        .push_wd_i   (bus.mdu_wd),
        .pop_i       (pop),
        .kill_i      (kill),
        .kill_wa_i   (bus.pipe_wa),
        .q_addr_i    (bus.q_addr),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .q_pending_o (fifo_q_pending)
    );

    // Source selection: pipe first, then a live head, else retire a dead head.
    always_comb begin
        sel = SEL_NONE;
        if (bus.pipe_valid) begin
            sel = SEL_PIPE;
        end else if (!fifo_empty) begin
            sel = head.live ? SEL_MDU : SEL_DROP;
        end
    end

    // Write-port next state; writes to x0 update address/data but not the enable.
    always_comb begin
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        case (sel)
            SEL_PIPE: begin
                rf_wa_d = bus.pipe_wa;
                rf_wd_d = bus.pipe_wd;
                rf_we_d = (bus.pipe_wa != REG_ZERO);
            end
            SEL_MDU: begin
                rf_wa_d = head.wa;
                rf_wd_d = head.wd;
                rf_we_d = (head.wa != REG_ZERO);
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase
    end

    // Starvation count: blocked cycles of a non-empty buffer, saturating.
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (bus.pipe_valid && (starve_q != CW'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
        stall_req_d = (starve_d == CW'(STARVE_MAX));
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q     <= 1'b0;
            rf_wa_q     <= '0;
            rf_wd_q     <= '0;
            starve_q    <= '0;
            stall_req_q <= 1'b0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_wa_q     <= rf_wa_d;
            rf_wd_q     <= rf_wd_d;
            starve_q    <= starve_d;
            stall_req_q <= stall_req_d;
        end
    end

    assign bus.mdu_ready = !fifo_full;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_wa     = rf_wa_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.q_pending = fifo_q_pending;
    assign bus.stall_req = stall_req_q;
    assign bus.dbg_sel   = sel;

`ifdef RF_WRITE_BYPASS_EN
    // Forward the in-flight regfile write to same-cycle readers.
    always_comb begin
        bus.byp_hit1 = rf_we_q && (rf_wa_q == bus.byp_ra1) && (bus.byp_ra1 != REG_ZERO);
        bus.byp_hit2 = rf_we_q && (rf_wa_q == bus.byp_ra2) && (bus.byp_ra2 != REG_ZERO);
        bus.byp_rd1  = bus.byp_hit1 ? rf_wd_q : '0;
        bus.byp_rd2  = bus.byp_hit2 ? rf_wd_q : '0;
    end
`endif

    // The pipeline is expected to hold writeback while stall_req is high.
    a_no_pipe_during_stall: assert property (
        @(posedge clk) disable iff (rst) !(stall_req_q && bus.pipe_valid)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed openers, then randomized phases checked
// against a queue-based reference model of the writeback rules.
// Optional feature macro: RF_WRITE_BYPASS_EN enables the bypass checks.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model buffer, oldest first: {live, wa[4:0], wd[31:0]}.
    logic [37:0] exp_q[$];
    int          starve;
    bit          exp_stall;
    bit          mdu_hold;
`ifdef RF_WRITE_BYPASS_EN
    bit          last_we;
    logic [4:0]  last_wa;
    logic [31:0] last_wd;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_pending(input logic [4:0] a);
        bit hit = 1'b0;
        if (a != 5'd0) begin
            foreach (exp_q[i]) begin
                if (exp_q[i][37] && (exp_q[i][36:32] == a)) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // One cycle of the writeback rules applied to the current inputs.
    task automatic model_step(output bit upd, output bit we, output logic [4:0] wa,
                              output logic [31:0] wd);
        int          n   = exp_q.size();
        bit          rdy = (n < DEPTH);
        logic [37:0] e;
        upd = 1'b0;
        we  = 1'b0;
        wa  = '0;
        wd  = '0;
        if (bus.pipe_valid) begin
            upd = 1'b1;
            wa  = bus.pipe_wa;
            wd  = bus.pipe_wd;
            we  = (bus.pipe_wa != 5'd0);
            if (bus.pipe_wa != 5'd0) begin
                foreach (exp_q[i]) begin
                    if (exp_q[i][36:32] == bus.pipe_wa) exp_q[i][37] = 1'b0;
                end
            end
        end else if (n > 0) begin
            e = exp_q.pop_front();
            if (e[37]) begin
                upd = 1'b1;
                we  = 1'b1;
                wa  = e[36:32];
                wd  = e[31:0];
            end
        end
        if (bus.mdu_valid && rdy && (bus.mdu_wa != 5'd0)) begin
            exp_q.push_back({!(bus.pipe_valid && (bus.pipe_wa == bus.mdu_wa)),
                             bus.mdu_wa, bus.mdu_wd});
        end
        mdu_hold = bus.mdu_valid && !rdy;
        if (bus.pipe_valid && (n > 0)) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
        else starve = 0;
        exp_stall = (starve == STARVE_MAX);
`ifdef RF_WRITE_BYPASS_EN
        last_we = we;
        if (upd) begin
            last_wa = wa;
            last_wd = wd;
        end
`endif
    endtask

    // Inputs are already applied; check comb outputs, clock, check registered outputs.
    task automatic run_cycle();
        bit          upd, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        #1;
        check("mdu_ready", bus.mdu_ready, exp_q.size() < DEPTH);
        check("q_pending", bus.q_pending, model_pending(bus.q_addr));
`ifdef RF_WRITE_BYPASS_EN
        check("byp_hit1", bus.byp_hit1, last_we && (last_wa == bus.byp_ra1) && (bus.byp_ra1 != 5'd0));
        check("byp_rd1", bus.byp_rd1,
              (last_we && (last_wa == bus.byp_ra1) && (bus.byp_ra1 != 5'd0)) ? last_wd : 32'd0);
        check("byp_hit2", bus.byp_hit2, last_we && (last_wa == bus.byp_ra2) && (bus.byp_ra2 != 5'd0));
`endif
        model_step(upd, we, wa, wd);
        @(posedge clk);
        #1;
        check("rf_we", bus.rf_we, we);
        if (upd) begin
            check("rf_wa", bus.rf_wa, wa);
            check("rf_wd", bus.rf_wd, wd);
        end
        check("stall_req", bus.stall_req, exp_stall);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.pipe_valid = 1'b0;
        bus.mdu_valid  = 1'b0;
        bus.q_addr     = (exp_q.size() > 0) ? exp_q[0][36:32] : 5'd3;
        @(posedge clk);
        #1;
        check("rst_rf_we", bus.rf_we, 1'b0);
        check("rst_rf_wa", bus.rf_wa, 5'd0);
        check("rst_rf_wd", bus.rf_wd, 32'd0);
        check("rst_stall", bus.stall_req, 1'b0);
        check("rst_ready", bus.mdu_ready, 1'b1);
        check("rst_q_pending", bus.q_pending, 1'b0);
        exp_q.delete();
        starve    = 0;
        exp_stall = 1'b0;
        mdu_hold  = 1'b0;
`ifdef RF_WRITE_BYPASS_EN
        last_we = 1'b0;
        last_wa = '0;
        last_wd = '0;
`endif
        rst = 1'b0;
    endtask

    task automatic drive_random(input int pipe_pct, input int mdu_pct);
        bus.pipe_valid = !exp_stall && ($urandom_range(0, 99) < pipe_pct);
        bus.pipe_wa    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        bus.pipe_wd    = $urandom;
        if (!mdu_hold) begin
            bus.mdu_valid = ($urandom_range(0, 99) < mdu_pct);
            bus.mdu_wa    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            bus.mdu_wd    = $urandom;
        end
        bus.q_addr = 5'($urandom_range(0, 7));
`ifdef RF_WRITE_BYPASS_EN
        bus.byp_ra1 = $urandom_range(0, 1) ? last_wa : 5'($urandom_range(0, 7));
        bus.byp_ra2 = 5'($urandom_range(0, 7));
`endif
    endtask

    int ph_pipe [6] = '{50, 90, 100, 10, 0, 60};
    int ph_mdu  [6] = '{50, 70, 60, 80, 30, 40};
    int ph_len  [6] = '{300, 300, 100, 200, 100, 400};

    initial begin
        rst            = 1'b1;
        bus.pipe_valid = 1'b0;
        bus.pipe_wa    = '0;
        bus.pipe_wd    = '0;
        bus.mdu_valid  = 1'b0;
        bus.mdu_wa     = '0;
        bus.mdu_wd     = '0;
        bus.q_addr     = '0;
`ifdef RF_WRITE_BYPASS_EN
        bus.byp_ra1 = '0;
        bus.byp_ra2 = '0;
`endif
        @(posedge clk);
        do_reset();

        // Basic pipe write, then a pipe write to x0.
        bus.pipe_valid = 1'b1; bus.pipe_wa = 5'd5; bus.pipe_wd = 32'hDEADBEEF;
        run_cycle();
        bus.pipe_wa = 5'd0; bus.pipe_wd = 32'h12345678;
        run_cycle();

        // Two MDU results queued while the pipe is idle, then drained.
        bus.pipe_valid = 1'b0;
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd7; bus.mdu_wd = 32'h11; bus.q_addr = 5'd8;
        run_cycle();
        bus.mdu_wa = 5'd8; bus.mdu_wd = 32'h22;
        run_cycle();
        bus.mdu_valid = 1'b0;
        run_cycle();
        run_cycle();

        // Buffered wa=3 killed by a younger pipe write to 3, then retired silently.
        bus.pipe_valid = 1'b1; bus.pipe_wa = 5'd1; bus.pipe_wd = 32'h1;
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd3; bus.mdu_wd = 32'hAA; bus.q_addr = 5'd3;
        run_cycle();
        bus.mdu_valid = 1'b0; bus.pipe_wa = 5'd3; bus.pipe_wd = 32'hBB;
        run_cycle();
        bus.pipe_valid = 1'b0;
        run_cycle();
        run_cycle();

        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < ph_len[p]; c++) begin
                drive_random(ph_pipe[p], ph_mdu[p]);
                run_cycle();
            end
            if (p == 2) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
